// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants and the
// 2-of-3 vote used when UART_RX_MAJORITY_EN is defined.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int OS_RATE = 16;
    localparam int OS_W    = 4;

    localparam logic [OS_W-1:0] SAMPLE_MID = 4'd8;
    localparam logic [OS_W-1:0] SAMPLE_LO  = 4'd7;
    localparam logic [OS_W-1:0] SAMPLE_HI  = 4'd9;
    localparam logic [OS_W-1:0] OS_LAST    = OS_W'(OS_RATE - 1);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rx_in synchronizer (flops reset to idle-high) with falling-edge detect on
// the synchronized line.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    output logic rx_s,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign rx_s = r_sync[SYNC_STAGES-1];
    assign fall = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with 16x oversampling and a one-entry valid/ready holding
// register. Define UART_RX_MAJORITY_EN for 2-of-3 voting at os_cnt 7/8/9.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int                BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic                 w_rx_s;
    logic                 w_fall;
    logic                 w_bit;
    logic                 w_decide;
    logic                 w_wend;

    state_t               r_state;
    logic [OS_W-1:0]      r_os;
    logic [BIT_W-1:0]     r_bit;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_ovr;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx_in(rx_in),
        .rx_s (w_rx_s),
        .fall (w_fall)
    );

`ifdef UART_RX_MAJORITY_EN
    localparam logic [OS_W-1:0] DECIDE = SAMPLE_HI;
    logic [1:0] r_votes;

    // Early votes are only meaningful inside a window, so they need no reset.
    always_ff @(posedge clk) begin
        if (baud_tick && r_os == SAMPLE_LO) r_votes[0] <= w_rx_s;
        if (baud_tick && r_os == SAMPLE_MID) r_votes[1] <= w_rx_s;
    end

    assign w_bit = maj3(r_votes[0], r_votes[1], w_rx_s);
`else
    localparam logic [OS_W-1:0] DECIDE = SAMPLE_MID;

    assign w_bit = w_rx_s;
`endif

    assign w_decide = baud_tick && (r_os == DECIDE);
    assign w_wend   = baud_tick && (r_os == OS_LAST);

    always_ff @(posedge clk) begin
        if (r_state == DATA && w_decide) r_shreg <= {w_bit, r_shreg[DATA_BITS-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_os    <= '0;
            r_bit   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
            if (r_valid && rx_ready) r_valid <= 1'b0;
            if (r_state != IDLE && baud_tick) r_os <= r_os + 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_os    <= '0;
                        r_bit   <= '0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_decide && w_bit) r_state <= IDLE;
                    else if (w_wend) r_state <= DATA;
                end
                DATA: begin
                    if (w_wend) begin
                        if (r_bit == LAST_BIT) r_state <= STOP;
                        else r_bit <= r_bit + 1'b1;
                    end
                end
                STOP: begin
                    // Leaving at mid-stop lets the next start edge arrive early.
                    if (w_decide) begin
                        r_state <= IDLE;
                        if (!w_bit) begin
                            r_ferr <= 1'b1;
                        end else if (!r_valid || rx_ready) begin
                            r_data  <= r_shreg;
                            r_valid <= 1'b1;
                        end else begin
                            r_ovr <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Randomized and directed bench for uart_rx_os16 against a tick-counting line
// model; honours UART_RX_MAJORITY_EN.
module tb_uart_rx_os16;

    localparam int DATA_BITS   = 8;
    localparam int SYNC_STAGES = 2;
`ifdef UART_RX_MAJORITY_EN
    localparam bit MAJ = 1'b1;
`else
    localparam bit MAJ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx_in = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int tick_per = 8;
    bit rdy_rand = 1'b0;
    bit rdy_fix = 1'b0;

    int obs_valid = 0;
    int obs_ferr = 0;
    int obs_ovr = 0;

    // Reference model: line delayed by the synchronizer, ticks counted from the edge.
    bit       m_q[$];
    bit       m_busy = 1'b0;
    int       m_t = 0;
    bit       m_lprev = 1'b1;
    bit [7:0] m_shift = 8'h00;
    bit       m_s0 = 1'b1;
    bit       m_s1 = 1'b1;
    bit       m_valid = 1'b0;
    bit [7:0] m_data = 8'h00;
    bit       m_ferr = 1'b0;
    bit       m_ovr = 1'b0;

    uart_rx_os16 #(
        .DATA_BITS  (DATA_BITS),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .baud_tick(baud_tick),
        .rx_in    (rx_in),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            cnt++;
            if (cnt >= tick_per) begin
                baud_tick = 1'b1;
                cnt = 0;
            end else begin
                baud_tick = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            rx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < SYNC_STAGES; i++) m_q.push_back(1'b1);
        m_busy = 1'b0;
        m_t = 0;
        m_lprev = 1'b1;
        m_valid = 1'b0;
        m_data = 8'h00;
        m_ferr = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic model_step();
        bit lin, v, dec, good;
        int b, ph;
        v = 1'b0;
        dec = 1'b0;
        good = 1'b0;
        lin = m_q.pop_front();
        m_q.push_back(rx_in);
        m_ferr = 1'b0;
        m_ovr = 1'b0;
        if (!m_busy) begin
            if (m_lprev && !lin) begin
                m_busy = 1'b1;
                m_t = 0;
            end
        end else if (baud_tick) begin
            m_t++;
            b = (m_t - 1) / 16;
            ph = (m_t - 1) % 16;
            if (MAJ) begin
                if (ph == 7) m_s0 = lin;
                if (ph == 8) m_s1 = lin;
                if (ph == 9) begin
                    dec = 1'b1;
                    v = (int'(m_s0) + int'(m_s1) + int'(lin)) >= 2;
                end
            end else if (ph == 8) begin
                dec = 1'b1;
                v = lin;
            end
            if (dec) begin
                if (b == 0) begin
                    if (v) m_busy = 1'b0;
                end else if (b <= DATA_BITS) begin
                    m_shift[b-1] = v;
                end else begin
                    m_busy = 1'b0;
                    if (v) good = 1'b1;
                    else m_ferr = 1'b1;
                end
            end
        end
        m_lprev = lin;
        if (good) begin
            if (!m_valid || rx_ready) begin
                m_data = m_shift;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rx_ready) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("rx_valid", int'(rx_valid), int'(m_valid));
            chk("rx_data", int'(rx_data), int'(m_data));
            chk("frame_err", int'(frame_err), int'(m_ferr));
            chk("overrun", int'(overrun), int'(m_ovr));
            if (rx_valid) obs_valid++;
            if (frame_err) obs_ferr++;
            if (overrun) obs_ovr++;
        end
    end

    task automatic wait_ticks(input int n);
        int guard;
        repeat (n) begin
            guard = 0;
            @(posedge clk);
            while (!baud_tick) begin
                guard++;
                if (guard > 100) begin
                    $display("FAIL tick_wait: got no baud_tick within 100 clk");
                    $fatal(1, "tick generator stalled");
                end
                @(posedge clk);
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input int n);
        rx_in = v;
        wait_ticks(n);
    endtask

    task automatic send_frame(input bit [7:0] d, input int stop_ticks, input bit stop_v,
                              input int glitch_bit);
        wait_ticks(1);
        drive(1'b0, 16);
        for (int i = 0; i < DATA_BITS; i++) begin
            if (i == glitch_bit) begin
                drive(d[i], 8);
                drive(~d[i], 1);
                drive(d[i], 7);
            end else begin
                drive(d[i], 16);
            end
        end
        drive(stop_v, stop_ticks);
        rx_in = 1'b1;
    endtask

    task automatic clear_obs();
        @(negedge clk);
        obs_valid = 0;
        obs_ferr = 0;
        obs_ovr = 0;
    endtask

    initial begin
        bit [7:0] e7;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_valid", int'(rx_valid), 0);
        chk("reset_data", int'(rx_data), 0);
        chk("reset_ferr", int'(frame_err), 0);
        chk("reset_ovr", int'(overrun), 0);
        rst = 1'b0;
        rdy_fix = 1'b1;

        // Single frame, consumer always ready.
        clear_obs();
        send_frame(8'hA5, 16, 1'b1, -1);
        wait_ticks(4);
        chk("a5_data", int'(rx_data), 'hA5);
        chk("a5_model_data", int'(m_data), 'hA5);
        chk("a5_valid_cycles", obs_valid, 1);
        chk("a5_flags", obs_ferr + obs_ovr, 0);

        // Two frames with the consumer stalled.
        rdy_fix = 1'b0;
        clear_obs();
        send_frame(8'h3C, 16, 1'b1, -1);
        send_frame(8'hC3, 16, 1'b1, -1);
        wait_ticks(4);
        chk("ovr_data_held", int'(rx_data), 'h3C);
        chk("ovr_valid", int'(rx_valid), 1);
        chk("ovr_pulses", obs_ovr, 1);
        rdy_fix = 1'b1;
        repeat (4) @(negedge clk);
        chk("ovr_drained", int'(rx_valid), 0);

        // Short low pulse is a false start; the next frame still arrives.
        clear_obs();
        wait_ticks(1);
        drive(1'b0, 4);
        rx_in = 1'b1;
        wait_ticks(30);
        chk("false_start_valid", obs_valid, 0);
        send_frame(8'h11, 16, 1'b1, -1);
        wait_ticks(4);
        chk("after_false_data", int'(rx_data), 'h11);
        chk("after_false_valid", obs_valid, 1);

        // Stop bit low.
        clear_obs();
        send_frame(8'h55, 16, 1'b0, -1);
        wait_ticks(20);
        chk("ferr_pulses", obs_ferr, 1);
        chk("ferr_valid", obs_valid, 0);

        // Held-low break.
        clear_obs();
        wait_ticks(1);
        drive(1'b0, 400);
        rx_in = 1'b1;
        wait_ticks(20);
        chk("break_ferr", obs_ferr, 1);
        chk("break_valid", obs_valid, 0);

        // One-tick glitch at the centre of data bit 3.
        clear_obs();
        send_frame(8'h81, 16, 1'b1, 3);
        wait_ticks(4);
        chk("glitch_data", int'(rx_data), MAJ ? 'h81 : 'h89);
        chk("glitch_valid", obs_valid, 1);

        // Reset in the middle of data bit 4, then a clean frame.
        e7 = 8'hE7;
        wait_ticks(1);
        drive(1'b0, 16);
        for (int i = 0; i < 4; i++) drive(e7[i], 16);
        drive(e7[4], 8);
        rst = 1'b1;
        rx_in = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_obs();
        wait_ticks(20);
        chk("abort_valid", obs_valid, 0);
        send_frame(8'h0F, 16, 1'b1, -1);
        wait_ticks(4);
        chk("after_rst_data", int'(rx_data), 'h0F);
        chk("after_rst_valid", obs_valid, 1);
        chk("after_rst_flags", obs_ferr + obs_ovr, 0);

        // Random frames, random consumer, random stop lengths and tick rates.
        rdy_rand = 1'b1;
        for (int f = 0; f < 25; f++) begin
            tick_per = $urandom_range(3, 6);
            send_frame(8'($urandom_range(0, 255)), $urandom_range(9, 20),
                       ($urandom_range(0, 9) != 0), -1);
            wait_ticks($urandom_range(0, 5));
        end
        rdy_rand = 1'b0;
        rdy_fix = 1'b1;
        wait_ticks(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
